ps2_keyboard_rx: RTL and testbench

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_dat` pins and turns them into decoded key events. It sits directly upstream of the CPU core and drives the 16-bit `ps2_data` word that the register file exposes as read-only R15. Firmware polls R15 and detects new keys by watching a rolling sequence count, so the block needs no read strobe from the CPU. It handles E0 (extended) and F0 (break) prefixes, odd parity, stop-bit checking, clock-glitch filtering and frame timeout.

---
 rtl/ps2_keyboard_rx.sv | 167 ++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and filters the raw pins, frames 11-bit
// packets and folds E0/F0 prefixes into a 16-bit key event word for the CPU.
module ps2_keyboard_rx #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_dat,
   output logic [15:0] ps2_data,
   output logic        key_valid,
   output logic        frame_err
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT);

   logic [1:0]    clk_sync_q, dat_sync_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          tick_q, tick_d;
   logic [1:0]    state_q, state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [3:0]    seq_q, seq_d;
   logic          ext_q, ext_d;
   logic          brk_q, brk_d;
   logic [15:0]   data_q, data_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          dat_s;

   assign dat_s = dat_sync_q[1];

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      filt_d     = filt_q;
      filt_cnt_d = '0;
      tick_d     = 1'b0;
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      to_cnt_d   = to_cnt_q;
      seq_d      = seq_q;
      ext_d      = ext_q;
      brk_d      = brk_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;

      // Filtered level flips on the FILTER_LEN-th consecutive disagreeing sample.
      if (clk_sync_q[1] != filt_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            filt_d = ~filt_q;
            tick_d = filt_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end

      if (state_q == ST_IDLE) begin
         to_cnt_d = '0;
         if (tick_q && !dat_s) begin
            state_d  = ST_DATA;
            bitcnt_d = 3'd0;
         end
      end else if (tick_q) begin
         // A tick always wins over a coincident timeout.
         to_cnt_d = '0;
         case (state_q)
            ST_DATA: begin
               shift_d  = {dat_s, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_d   = dat_s;
               state_d = ST_STOP;
            end
            default: begin
               state_d = ST_IDLE;
               if (dat_s && ((^shift_q) ^ par_q)) begin
                  if (shift_q == 8'hE0) begin
                     ext_d = 1'b1;
                  end else if (shift_q == 8'hF0) begin
                     brk_d = 1'b1;
                  end else begin
                     data_d  = {seq_q + 4'd1, 2'b00, ext_q, brk_q, shift_q};
                     seq_d   = seq_q + 4'd1;
                     valid_d = 1'b1;
                     ext_d   = 1'b0;
                     brk_d   = 1'b0;
                  end
               end else begin
                  err_d = 1'b1;
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
            end
         endcase
      end else if (to_cnt_q == TO_LIMIT) begin
         state_d  = ST_IDLE;
         to_cnt_d = '0;
         err_d    = 1'b1;
         ext_d    = 1'b0;
         brk_d    = 1'b0;
      end else begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a false start edge.
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
         tick_q     <= 1'b0;
         state_q    <= ST_IDLE;
         bitcnt_q   <= 3'd0;
         shift_q    <= 8'h00;
         par_q      <= 1'b0;
         to_cnt_q   <= '0;
         seq_q      <= 4'd0;
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         data_q     <= 16'h0000;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[0], ps2_clk};
         dat_sync_q <= {dat_sync_q[0], ps2_dat};
         filt_q     <= filt_d;
         filt_cnt_q <= filt_cnt_d;
         tick_q     <= tick_d;
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         to_cnt_q   <= to_cnt_d;
         seq_q      <= seq_d;
         ext_q      <= ext_d;
         brk_q      <= brk_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   assign ps2_data  = data_q;
   assign key_valid = valid_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: hand-built PS/2 frames with hand-computed
// event words, pulse counts checked after each step.
module tb_ps2_keyboard_rx;

   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        ps2_clk;
   logic        ps2_dat;
   logic [15:0] ps2_data;
   logic        key_valid;
   logic        frame_err;

   int n_cmp = 0;
   int n_err = 0;
   int kv_cnt = 0;
   int fe_cnt = 0;
   int kv0, fe0;

   ps2_keyboard_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_dat   (ps2_dat),
      .ps2_data  (ps2_data),
      .key_valid (key_valid),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_valid === 1'b1) kv_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   // Sends the first nbits of {stop, parity, byte, start} LSB first; optional
   // short clock-low glitch after bit glitch_at.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                             input int nbits, input int glitch_at);
      logic [10:0] f;
      f = {stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = f[i];
         wait_cyc(10);
         ps2_clk = 1'b0;
         wait_cyc(20);
         ps2_clk = 1'b1;
         wait_cyc(10);
         if (i == glitch_at) begin
            ps2_clk = 1'b0;
            wait_cyc(FILTER_LEN - 2);
            ps2_clk = 1'b1;
            wait_cyc(12);
         end
      end
      ps2_dat = 1'b1;
      wait_cyc(20);
   endtask

   task automatic good(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, 11, -1);
   endtask

   task automatic mark;
      kv0 = kv_cnt;
      fe0 = fe_cnt;
   endtask

   task automatic check_pulses(input string tag, input int kv_exp, input int fe_exp);
      check({tag, "_kv"}, 16'(kv_cnt - kv0), 16'(kv_exp));
      check({tag, "_fe"}, 16'(fe_cnt - fe0), 16'(fe_exp));
   endtask

   initial begin
      rst = 1'b0;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      wait_cyc(5);
      check("rst_data", ps2_data, 16'h0000);
      check("rst_kv", {15'd0, key_valid}, 16'h0000);
      check("rst_fe", {15'd0, frame_err}, 16'h0000);
      rst = 1'b1;
      wait_cyc(5);

      mark; good(8'h1C);
      check("make", ps2_data, 16'h101C);
      check_pulses("make", 1, 0);

      mark; good(8'hF0); check_pulses("brk_prefix", 0, 0); good(8'h1C);
      check("brk", ps2_data, 16'h211C);
      check_pulses("brk", 1, 0);

      mark; good(8'hE0); good(8'h75);
      check("ext", ps2_data, 16'h3275);
      check_pulses("ext", 1, 0);

      mark; good(8'hE0); good(8'hF0); good(8'h75);
      check("ext_brk", ps2_data, 16'h4375);
      check_pulses("ext_brk", 1, 0);

      mark; send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
      check("bad_par", ps2_data, 16'h4375);
      check_pulses("bad_par", 0, 1);

      mark; send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
      check("bad_stop", ps2_data, 16'h4375);
      check_pulses("bad_stop", 0, 1);

      mark; good(8'h29);
      check("recover", ps2_data, 16'h5029);
      check_pulses("recover", 1, 0);

      mark; send_frame(8'hA5, 1'b0, 1'b1, 5, -1);
      wait_cyc(TIMEOUT + 10);
      check("timeout", ps2_data, 16'h5029);
      check_pulses("timeout", 0, 1);
      mark; good(8'h1C);
      check("post_to", ps2_data, 16'h601C);
      check_pulses("post_to", 1, 0);

      mark; send_frame(8'h1C, 1'b0, 1'b1, 11, 4);
      check("glitch", ps2_data, 16'h701C);
      check_pulses("glitch", 1, 0);

      mark;
      for (int i = 0; i < 17; i++) begin
         good(8'(8'h10 + i));
         if (i == 7)  check("seq_f", ps2_data, 16'hF017);
         if (i == 8)  check("seq_wrap0", ps2_data, 16'h0018);
         if (i == 9)  check("seq_wrap1", ps2_data, 16'h1019);
      end
      check("seq_end", ps2_data, 16'h8020);
      check_pulses("seq", 17, 0);

      mark; send_frame(8'h3C, 1'b0, 1'b1, 6, -1);
      rst = 1'b0;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      wait_cyc(3);
      check("mid_rst_data", ps2_data, 16'h0000);
      check("mid_rst_kv", {15'd0, key_valid}, 16'h0000);
      check("mid_rst_fe", {15'd0, frame_err}, 16'h0000);
      rst = 1'b1;
      wait_cyc(20);
      check_pulses("mid_rst", 0, 0);
      mark; good(8'h1C);
      check("post_rst", ps2_data, 16'h101C);
      check_pulses("post_rst", 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
